// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver.
// Contents:
//   PS2_EXT / PS2_BRK : scan-code prefixes for extended keys and key release
//   EVT_W             : width of a key-event word {ext, brk, code[7:0]}
//   rx_state_t        : deframer state encoding
package ps2_pkg;

   localparam logic [7:0] PS2_EXT = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;
   localparam int         EVT_W   = 10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } rx_state_t;

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Bus bundle between the PS/2 receiver and its environment.
// Signals:
//   ps2_clk, ps2_data : raw PS/2 pins (asynchronous to the system clock)
//   rd_en, clr_ovf    : consumer pops the head event / clears sticky overflow
//   rd_data           : head event {ext, brk, code}, valid while ready=1
//   ready             : FIFO non-empty
//   overflow          : sticky, an event was dropped on a full FIFO
//   frame_err         : one-cycle pulse on parity, stop or timeout error
//   count             : FIFO occupancy
// Modports: master = pin/consumer side, slave = receiver.
interface ps2_rx_fifo_if
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic             ps2_clk;
   logic             ps2_data;
   logic             rd_en;
   logic             clr_ovf;
   logic [EVT_W-1:0] rd_data;
   logic             ready;
   logic             overflow;
   logic             frame_err;
   logic [CW-1:0]    count;

   modport master (
      output ps2_clk, ps2_data, rd_en, clr_ovf,
      input  rd_data, ready, overflow, frame_err, count
   );

   modport slave (
      input  ps2_clk, ps2_data, rd_en, clr_ovf,
      output rd_data, ready, overflow, frame_err, count
   );

endinterface

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO with overflow tracking.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   push, push_data : write request and data
//   pop             : remove head entry (ignored when empty)
//   clr_ovf         : clear sticky overflow (a new drop in the same cycle wins)
//   rd_data         : head entry, read combinationally from storage
//   full, empty     : occupancy flags
//   count           : occupancy, 0..DEPTH
//   overflow        : sticky, set when a push was dropped
module sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   input  logic                       clr_ovf,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;
   logic             drop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   // A full FIFO still accepts a push when a pop frees the head slot in the same cycle.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign drop    = push & full & ~do_pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         if (drop) begin
            overflow <= 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronises the PS/2 pins, deframes 11-bit frames
// (start, 8 data LSB first, odd parity, stop), folds E0/F0 prefixes into
// key-event words and buffers them in a FWFT FIFO.
// Ports:
//   clk_i : system clock
//   rst_n : asynchronous active-low reset
//   bus   : ps2_rx_fifo_if slave (pins, consumer handshake, status)
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH    = 8,
   parameter int TIMEOUT_CYC   = 5000,
   parameter int SYNC_STAGES   = 2,
   parameter int DECODE_PREFIX = 1
) (
   input  logic         clk_i,
   input  logic         rst_n,
   ps2_rx_fifo_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   clk_prev;
   logic                   clk_s;
   logic                   data_s;
   logic                   fall;

   rx_state_t              state;
   logic [2:0]             bit_cnt;
   logic [7:0]             shift;
   logic                   par;
   logic [TW-1:0]          tmo_cnt;
   logic                   byte_valid;
   logic [7:0]             rx_byte;
   logic                   frame_err;

   logic                   ext_p;
   logic                   brk_p;
   logic                   is_prefix;
   logic                   push;
   logic [EVT_W-1:0]       push_data;
   logic                   fifo_full;
   logic                   fifo_empty;

   // Synchroniser chains; clk_prev resets to 0 so an idle-high line never looks like a falling edge.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync  <= '0;
         data_sync <= '0;
         clk_prev  <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], bus.ps2_clk};
         data_sync <= {data_sync[SYNC_STAGES-2:0], bus.ps2_data};
         clk_prev  <= clk_s;
      end
   end

   assign clk_s  = clk_sync[SYNC_STAGES-1];
   assign data_s = data_sync[SYNC_STAGES-1];
   assign fall   = clk_prev & ~clk_s;

   // Deframer. The stall timer runs only mid-frame; an expiry overrides any state change.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shift      <= '0;
         par        <= 1'b0;
         tmo_cnt    <= '0;
         byte_valid <= 1'b0;
         rx_byte    <= '0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;

         if (state == IDLE || fall) begin
            tmo_cnt <= '0;
         end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
         end

         case (state)
            IDLE: begin
               if (fall && !data_s) begin
                  state   <= DATA;
                  bit_cnt <= '0;
               end
            end
            DATA: begin
               if (fall) begin
                  shift   <= {data_s, shift[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     state <= PARITY;
                  end
               end
            end
            PARITY: begin
               if (fall) begin
                  par   <= data_s;
                  state <= STOP;
               end
            end
            STOP: begin
               if (fall) begin
                  if (data_s && (^{shift, par})) begin
                     byte_valid <= 1'b1;
                     rx_byte    <= shift;
                  end else begin
                     frame_err <= 1'b1;
                  end
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (state != IDLE && !fall && tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
            state     <= IDLE;
            frame_err <= 1'b1;
         end
      end
   end

   assign is_prefix = (DECODE_PREFIX != 0) && (rx_byte == PS2_EXT || rx_byte == PS2_BRK);
   assign push      = byte_valid & ~is_prefix;
   assign push_data = (DECODE_PREFIX != 0) ? {ext_p, brk_p, rx_byte} : {2'b00, rx_byte};

   // Prefix flags accumulate until a non-prefix byte consumes them; any frame error discards them.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         ext_p <= 1'b0;
         brk_p <= 1'b0;
      end else if (frame_err) begin
         ext_p <= 1'b0;
         brk_p <= 1'b0;
      end else if (byte_valid && DECODE_PREFIX != 0) begin
         if (rx_byte == PS2_EXT) begin
            ext_p <= 1'b1;
         end else if (rx_byte == PS2_BRK) begin
            brk_p <= 1'b1;
         end else begin
            ext_p <= 1'b0;
            brk_p <= 1'b0;
         end
      end
   end

   sync_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk_i),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_data),
      .pop       (bus.rd_en),
      .clr_ovf   (bus.clr_ovf),
      .rd_data   (bus.rd_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (bus.count),
      .overflow  (bus.overflow)
   );

   assign bus.ready     = ~fifo_empty;
   assign bus.frame_err = frame_err;

endmodule
